// File: rtl/palette_pkg.sv
// ============================================================================
// palette_pkg : shared widths, grant and fill-FSM encodings for palette writes
// Rev 1.0
// ============================================================================
`default_nettype none

package palette_pkg;

  localparam int PAL_ADDR_W = 9;
  localparam int PAL_DATA_W = 32;

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_FILL = 1'b1
  } grant_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/palette_wr_fifo.sv
// ============================================================================
// palette_wr_fifo : synchronous FIFO with full/empty flags, head shown on dout
// Rev 1.0
// ============================================================================
`default_nettype none

module palette_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == c_DEPTH);
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/palette_write_ctrl.sv
// ============================================================================
// palette_write_ctrl : arbitrates host FIFO and block-fill writes onto the
// palette RAM write port, optionally confined to blanking.   Rev 1.0
// ============================================================================
`default_nettype none

module palette_write_ctrl
  import palette_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = PAL_ADDR_W,
  parameter int DATA_W     = PAL_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_count,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              blank,
  input  logic              defer_en,
  output logic              pal_we,
  output logic [ADDR_W-1:0] pal_addr,
  output logic [DATA_W-1:0] pal_din
);

  localparam int FW = ADDR_W + DATA_W;

  fill_state_e       r_state;
  fill_state_e       w_state_nxt;
  grant_e            r_last_gnt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_color;
  logic              r_ready_en;
  logic              r_pal_we;
  logic [ADDR_W-1:0] r_pal_addr;
  logic [DATA_W-1:0] r_pal_din;

  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [FW-1:0]     w_fifo_dout;
  logic              w_issue_ok;
  logic              w_host_cand;
  logic              w_fill_cand;
  logic              w_gnt_host;
  logic              w_gnt_fill;

  assign host_ready = r_ready_en && !w_full;
  assign w_push     = host_valid && host_ready;

  palette_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_din   ({host_addr, host_data}),
    .i_pop   (w_gnt_host),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // With both sources pending, grant whichever did not win last time.
  assign w_issue_ok  = !defer_en || blank;
  assign w_host_cand = !w_empty;
  assign w_fill_cand = (r_state == RUN);
  assign w_gnt_host  = w_issue_ok && w_host_cand && (!w_fill_cand || r_last_gnt == GNT_FILL);
  assign w_gnt_fill  = w_issue_ok && w_fill_cand && (!w_host_cand || r_last_gnt == GNT_HOST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (fill_start) w_state_nxt = (fill_count == '0) ? DONE : RUN;
      RUN:  if (w_gnt_fill && r_remaining == (ADDR_W+1)'(1)) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_color     <= '0;
    end else if (r_state == IDLE && fill_start && fill_count != '0) begin
      r_cur_addr  <= fill_base;
      r_remaining <= fill_count;
      r_color     <= fill_color;
    end else if (w_gnt_fill) begin
      r_cur_addr  <= r_cur_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready_en <= 1'b0;
      r_last_gnt <= GNT_FILL;
      r_pal_we   <= 1'b0;
      r_pal_addr <= '0;
      r_pal_din  <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_pal_we   <= w_gnt_host || w_gnt_fill;
      if (w_gnt_host) begin
        r_last_gnt <= GNT_HOST;
        r_pal_addr <= w_fifo_dout[FW-1:DATA_W];
        r_pal_din  <= w_fifo_dout[DATA_W-1:0];
      end else if (w_gnt_fill) begin
        r_last_gnt <= GNT_FILL;
        r_pal_addr <= r_cur_addr;
        r_pal_din  <= r_color;
      end
    end
  end

  assign pal_we    = r_pal_we;
  assign pal_addr  = r_pal_addr;
  assign pal_din   = r_pal_din;
  assign fill_busy = (r_state == RUN);
  assign fill_done = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_palette_write_ctrl.sv
// ============================================================================
// tb_palette_write_ctrl : directed self-checking bench for palette_write_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_palette_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [8:0]  host_addr;
  logic [31:0] host_data;
  logic        fill_start;
  logic [8:0]  fill_base;
  logic [9:0]  fill_count;
  logic [31:0] fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic        blank;
  logic        defer_en;
  logic        pal_we;
  logic [8:0]  pal_addr;
  logic [31:0] pal_din;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [40:0] wq[$];
  int          wc[$];

  always #5 clk = ~clk;

  palette_write_ctrl #(.FIFO_DEPTH(4), .ADDR_W(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_count (fill_count),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .blank      (blank),
    .defer_en   (defer_en),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_din    (pal_din)
  );

  always @(posedge clk) cyc++;

  // Write log sampled mid-cycle.
  always @(negedge clk) begin
    if (pal_we === 1'b1) begin
      wq.push_back({pal_addr, pal_din});
      wc.push_back(cyc);
    end
    if (fill_done === 1'b1) done_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wq.delete();
    wc.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; host_valid = 1'b0; fill_start = 1'b0;
    blank = 1'b0; defer_en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic host_push(input logic [8:0] a, input logic [31:0] d);
    host_valid = 1'b1; host_addr = a; host_data = d;
    tick(1);
    host_valid = 1'b0;
  endtask

  task automatic fill_go(input logic [8:0] b, input logic [9:0] n, input logic [31:0] c);
    fill_start = 1'b1; fill_base = b; fill_count = n; fill_color = c;
    tick(1);
    fill_start = 1'b0;
  endtask

  initial begin
    logic [8:0]  exp_a [19];
    logic [31:0] exp_d [19];
    int hits [512];
    int bad, bad_d;

    reset = 1'b1; host_valid = 1'b0; host_addr = '0; host_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_color = '0;
    blank = 1'b0; defer_en = 1'b0;
    tick(2);
    chk("rst_we",    pal_we, 0);
    chk("rst_addr",  pal_addr, 0);
    chk("rst_din",   pal_din, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_busy",  fill_busy, 0);
    chk("rst_done",  fill_done, 0);
    reset = 1'b0;
    tick(1);
    chk("post_rst_ready", host_ready, 1);

    // Single host write, minimum latency
    do_reset(); clear_log();
    host_push(9'h005, 32'h00FF8040);
    chk("h1_we_n1", pal_we, 0);
    tick(1);
    chk("h1_we_n2", pal_we, 1);
    chk("h1_addr",  pal_addr, 9'h005);
    chk("h1_din",   pal_din, 32'h00FF8040);
    tick(1);
    chk("h1_we_n3", pal_we, 0);
    tick(3);
    chk("h1_count", wq.size(), 1);

    // Wrapping fill of 4
    do_reset(); clear_log();
    exp_a[0] = 9'h1FE; exp_a[1] = 9'h1FF; exp_a[2] = 9'h000; exp_a[3] = 9'h001;
    fill_go(9'h1FE, 10'd4, 32'h00112233);
    chk("f4_busy", fill_busy, 1);
    tick(10);
    chk("f4_count", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        chk($sformatf("f4_addr%0d", i), wq[i][40:32], exp_a[i]);
        chk($sformatf("f4_din%0d", i),  wq[i][31:0], 32'h00112233);
        chk($sformatf("f4_cyc%0d", i),  wc[i] - wc[0], i);
      end
    end
    chk("f4_done", done_cnt, 1);
    chk("f4_idle", fill_busy, 0);

    // Alternation: 3 host + 16 fill
    do_reset(); clear_log();
    defer_en = 1'b1;
    host_push(9'h010, 32'h00A00001);
    host_push(9'h011, 32'h00A00002);
    host_push(9'h012, 32'h00A00003);
    fill_go(9'h040, 10'd16, 32'h00ABCDEF);
    for (int k = 0; k < 3; k++) begin
      exp_a[2*k]   = 9'h010 + 9'(k);
      exp_d[2*k]   = 32'h00A00001 + k;
      exp_a[2*k+1] = 9'h040 + 9'(k);
      exp_d[2*k+1] = 32'h00ABCDEF;
    end
    for (int k = 3; k < 16; k++) begin
      exp_a[k+3] = 9'h040 + 9'(k);
      exp_d[k+3] = 32'h00ABCDEF;
    end
    blank = 1'b1;
    tick(30);
    chk("alt_count", wq.size(), 19);
    bad = 0;
    for (int i = 0; i < 19; i++)
      if (i >= wq.size() || wq[i] !== {exp_a[i], exp_d[i]}) bad++;
    chk("alt_order_errs", bad, 0);
    chk("alt_first", wq.size() > 0 ? wq[0] : 41'h0, {9'h010, 32'h00A00001});
    chk("alt_done", done_cnt, 1);

    // Deferral holds a full FIFO until blank
    do_reset(); clear_log();
    defer_en = 1'b1; blank = 1'b0;
    for (int i = 0; i < 4; i++) host_push(9'h100 + 9'(i), 32'h00C00000 + i);
    chk("def_full_ready", host_ready, 0);
    tick(5);
    chk("def_hold", wq.size(), 0);
    blank = 1'b1;
    tick(8);
    chk("def_count", wq.size(), 4);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= wq.size() || wq[i] !== {9'h100 + 9'(i), 32'h00C00000 + i} || wc[i] - wc[0] != i) bad++;
    chk("def_seq_errs", bad, 0);
    chk("def_ready_back", host_ready, 1);

    // Zero-length fill
    do_reset(); clear_log();
    fill_go(9'h000, 10'd0, 32'h12345678);
    chk("f0_done", fill_done, 1);
    chk("f0_busy", fill_busy, 0);
    tick(1);
    chk("f0_done_off", fill_done, 0);
    tick(3);
    chk("f0_writes", wq.size(), 0);
    chk("f0_pulses", done_cnt, 1);

    // Full-palette fill from 0x100
    clear_log();
    fill_go(9'h100, 10'd512, 32'h00550055);
    tick(520);
    chk("f512_count", wq.size(), 512);
    chk("f512_done", done_cnt, 1);
    chk("f512_busy", fill_busy, 0);
    for (int i = 0; i < 512; i++) hits[i] = 0;
    bad_d = 0;
    foreach (wq[i]) begin
      hits[int'(wq[i][40:32])]++;
      if (wq[i][31:0] !== 32'h00550055) bad_d++;
    end
    bad = 0;
    for (int i = 0; i < 512; i++) if (hits[i] != 1) bad++;
    chk("f512_cover_errs", bad, 0);
    chk("f512_data_errs", bad_d, 0);
    chk("f512_first", wq.size() > 0 ? wq[0][40:32] : 9'h1AA, 9'h100);

    // Reset mid-fill with host entries pending
    do_reset();
    defer_en = 1'b1; blank = 1'b0;
    host_push(9'h020, 32'h00000001);
    host_push(9'h021, 32'h00000002);
    fill_go(9'h000, 10'd100, 32'h00777777);
    chk("mr_busy_pre", fill_busy, 1);
    clear_log();
    reset = 1'b1; blank = 1'b1;
    tick(1);
    chk("mr_we_rst", pal_we, 0);
    chk("mr_ready_rst", host_ready, 0);
    reset = 1'b0;
    tick(1);
    chk("mr_busy_post", fill_busy, 0);
    chk("mr_ready_post", host_ready, 1);
    chk("mr_we_post", pal_we, 0);
    tick(110);
    chk("mr_writes", wq.size(), 0);
    chk("mr_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
